// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } key_state_t;

  // 20 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/key_debounce_toggle_if.sv
// Raw key inputs and conditioned per-key outputs of the debounce block.
interface key_debounce_toggle_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_toggle;

  modport master (
    output key_n,
    input  key_level, key_press, key_release, key_toggle
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, key_toggle
  );
endinterface

// File: rtl/debounce_cell.sv
// One key: 2-flop synchronizer, four-state debounce FSM with stability
// counter, and registered level/press/release/toggle outputs.
module debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rls,     // release pulse; "release" is a reserved word
  output logic toggle
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("debounce_cell: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [1:0]       sync;
  logic             key_s;
  key_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, press_d, rls_d, toggle_d;

  // Sync flops idle at 1 so a held key after reset still needs a full window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], key_n};
  end

  assign key_s = ~sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RELEASED;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rls    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      level  <= level_d;
      press  <= press_d;
      rls    <= rls_d;
      toggle <= toggle_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    level_d  = level;
    press_d  = 1'b0;
    rls_d    = 1'b0;
    toggle_d = toggle;
    unique case (state)
      RELEASED: begin
        if (key_s) begin
          state_d = PRESS_PEND;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_PEND: begin
        if (!key_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          level_d  = 1'b1;
          press_d  = 1'b1;
          toggle_d = ~toggle;
        end else begin
          cnt_d   = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_PEND;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      RELEASE_PEND: begin
        if (key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
          rls_d   = 1'b1;
        end else begin
          cnt_d   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_debounce_toggle.sv
// DE2 push-button conditioning: N_KEYS independent debounce cells.
module key_debounce_toggle
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  key_debounce_toggle_if.slave kif
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .key_n  (kif.key_n[g]),
      .level  (kif.key_level[g]),
      .press  (kif.key_press[g]),
      .rls    (kif.key_release[g]),
      .toggle (kif.key_toggle[g])
    );
  end

endmodule

// File: doc/key_debounce_toggle.md
Name: key_debounce_toggle

Overview:
- Upstream conditioning stage for the DE2 push-buttons.
- Synchronizes raw active-low KEY inputs to the 50 MHz clock and debounces each key with its own counter.
- Per key, produces:
  - a clean pressed level;
  - a one-cycle press pulse;
  - a one-cycle release pulse;
  - a toggle bit that flips on every accepted press.
- key_toggle[0] drives the 2:1 byte mux select on the test top, replacing the raw switch.

Parameters:
- N_KEYS, 4, number of independent keys.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a change (20 ms at 50 MHz). Must be >= 2; smaller values are an elaboration error.
- CNT_W, $clog2(DEBOUNCE_CYCLES), localparam, counter width; not overridable.

Ports:
- clk  input  1  system clock (CLOCK_50 at top).
- reset  input  1  asynchronous, active-high reset.
- key_n  input  N_KEYS  raw board keys, active-low, asynchronous to clk.
- key_level  output  N_KEYS  debounced state, 1 = pressed.
- key_press  output  N_KEYS  one-cycle pulse on accepted press.
- key_release  output  N_KEYS  one-cycle pulse on accepted release.
- key_toggle  output  N_KEYS  flips on each accepted press.

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - reset is asynchronous, active-high. All flops clear immediately on reset assertion.
- Synchronizer: two flops per key. Both reset to 1 (released). key_s = NOT second-stage value (1 = pressed).
- Per-key FSM, states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND. Reset state RELEASED, counter 0.
  - RELEASED:
    - key_s=1 -> PRESS_PEND, cnt<=1.
    - Otherwise stay, cnt<=0.
  - PRESS_PEND:
    - key_s=0 -> RELEASED, cnt<=0. This is a bounce; no outputs change.
    - key_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Same edge: key_level<=1, key_press<=1, key_toggle<=~key_toggle, cnt<=0.
    - Else cnt<=cnt+1.
  - PRESSED:
    - key_s=0 -> RELEASE_PEND, cnt<=1.
    - Otherwise stay.
  - RELEASE_PEND: mirror of PRESS_PEND.
    - key_s=1 -> PRESSED (bounce).
    - key_s=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED. Same edge: key_level<=0, key_release<=1.
- Outputs:
  - All outputs are registered.
  - key_press and key_release are high for exactly one cycle and clear on the following edge.
- Latency:
  - Let E0 be the first edge at which the first sync flop captures key_n=0.
  - The key stays low at every subsequent edge.
  - key_press and key_level rise after edge E0+DEBOUNCE_CYCLES+1. Release latency is symmetric.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Keys are fully independent. Simultaneous presses on several keys produce simultaneous pulses with no priority.
- Reset values: key_level=0, key_press=0, key_release=0, key_toggle=0.
- Reset mid-operation:
  - All FSMs return to RELEASED and counters clear; any in-progress debounce is lost.
  - A key held through reset deassertion needs a full debounce window. It then yields exactly one press pulse and one toggle.
- Glitch rejection: a pulse on key_n shorter than DEBOUNCE_CYCLES samples produces no output change.

Decomposition:
- Package key_debounce_pkg:
  - typedef enum logic [1:0] key_state_t {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND};
  - constant DEFAULT_DEBOUNCE_CYCLES = 1000000.
- Sub-module debounce_cell:
  - Contents: one key's synchronizer, FSM, counter and output flops.
  - Ports: clk, reset, key_n, level, press, release, toggle; parameter DEBOUNCE_CYCLES.
  - key_debounce_toggle instantiates N_KEYS cells in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, N_KEYS=4):
- Reset: hold reset with key_n=4'b0000 -> all outputs 0 during reset. After deassertion, key0 held low -> one key_press[0] pulse and key_toggle[0]=1 after edge E0+5; no further pulses while held.
- Clean press/release on key1: key_n[1] low for 20 cycles then high -> key_press[1] one cycle at E0+5; key_level[1]=1 until release is accepted 5 edges after the release sample; then key_release[1] pulses once and key_level[1]=0.
- Bounce rejection: key_n[2] low 3 cycles, high 1, low 3, high -> no pulses, key_level[2]=0, key_toggle[2]=0 throughout.
- Toggle/mux drive: three clean presses on key0 -> key_toggle[0] sequence 1,0,1. Mux output with SW[7:0]=8'hA5, SW[15:8]=8'h3C shows 8'h3C, 8'hA5, 8'h3C.
- Simultaneous keys: key_n=4'b0000 asserted on the same edge -> key_press=4'b1111 in the same single cycle.
- Reset mid-debounce: reset asserted when key3 has cnt=2 in PRESS_PEND -> outputs 0 immediately. After deassertion with key3 still low, the press pulse occurs a full 5 edges after resampling.
